// File: rtl/sync_fwft_fifo_ctrl.sv
// Single-clock FIFO controller with first-word-fall-through output.
// Owns the pointers of an external simple dual-port RAM (1-cycle registered
// read) and turns its read data into a valid/ready stream through a 2-entry
// output buffer.
module sync_fwft_fifo_ctrl #(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 1024,
  parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 4,
  parameter int ALMOST_EMPTY_TH = 2,
  localparam int AW             = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  overflow_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dout_valid_o,
  input  logic                  dout_ready_i,
  output logic                  almost_empty_o,
  output logic [AW+1:0]         data_count_o,
  output logic                  ram_wr_en_o,
  output logic [AW-1:0]         ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic [AW-1:0]         ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   AF_TH     = (AW+1)'(ALMOST_FULL_TH);
  localparam logic [AW+1:0] AE_TH     = (AW+2)'(ALMOST_EMPTY_TH);
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           ram_count_q, ram_count_d;
  logic                  in_flight_q, in_flight_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic                  overflow_q, overflow_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic [AW+1:0]         data_count_q, data_count_d;

  logic full_s, push_acc_s, rd_issue_s, pop_s, capture_s;

  // Handshake decode: push acceptance, read issue, pop and capture.
  always_comb begin
    full_s     = (ram_count_q == DEPTH_CNT);
    push_acc_s = wr_en_i & ~full_s & rst_n_i;
    rd_issue_s = (ram_count_q != {(AW+1){1'b0}}) &&
                 ((buf_cnt_q + {1'b0, in_flight_q}) < 2'd2);
    pop_s      = (buf_cnt_q != 2'd0) & dout_ready_i;
    capture_s  = in_flight_q;
  end

  // Pointer, RAM occupancy and in-flight next state.
  always_comb begin
    wr_ptr_d    = push_acc_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d    = rd_issue_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    in_flight_d = rd_issue_s;
    ram_count_d = ram_count_q;
    case ({push_acc_s, rd_issue_s})
      2'b10:   ram_count_d = ram_count_q + CNT_ONE;
      2'b01:   ram_count_d = ram_count_q - CNT_ONE;
      default: ram_count_d = ram_count_q;
    endcase
  end

  // Output buffer: shift on pop, append captured RAM data at the tail.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    case ({pop_s, capture_s})
      2'b01: begin
        if (buf_cnt_q == 2'd0) begin
          buf0_d = ram_rd_data_i;
        end else begin
          buf1_d = ram_rd_data_i;
        end
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b10: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        // Count stays; the captured word lands behind whatever remains.
        if (buf_cnt_q == 2'd1) begin
          buf0_d = ram_rd_data_i;
        end else begin
          buf0_d = buf1_q;
          buf1_d = ram_rd_data_i;
        end
      end
      default: begin
        buf_cnt_d = buf_cnt_q;
      end
    endcase
  end

  // Status flags follow the next-state counts so they update with them.
  always_comb begin
    overflow_d     = wr_en_i & full_s;
    data_count_d   = {1'b0, ram_count_d} + {{AW{1'b0}}, buf_cnt_d} +
                     {{(AW+1){1'b0}}, in_flight_d};
    almost_full_d  = (ram_count_d >= AF_TH);
    almost_empty_d = (data_count_d <= AE_TH);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q       <= {AW{1'b0}};
      rd_ptr_q       <= {AW{1'b0}};
      ram_count_q    <= {(AW+1){1'b0}};
      in_flight_q    <= 1'b0;
      buf_cnt_q      <= 2'd0;
      buf0_q         <= {DATA_WIDTH{1'b0}};
      buf1_q         <= {DATA_WIDTH{1'b0}};
      overflow_q     <= 1'b0;
      almost_full_q  <= (AF_TH == {(AW+1){1'b0}});
      almost_empty_q <= 1'b1;
      data_count_q   <= {(AW+2){1'b0}};
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      ram_count_q    <= ram_count_d;
      in_flight_q    <= in_flight_d;
      buf_cnt_q      <= buf_cnt_d;
      buf0_q         <= buf0_d;
      buf1_q         <= buf1_d;
      overflow_q     <= overflow_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      data_count_q   <= data_count_d;
    end
  end

  assign full_o         = full_s;
  assign almost_full_o  = almost_full_q;
  assign overflow_o     = overflow_q;
  assign dout_o         = buf0_q;
  assign dout_valid_o   = (buf_cnt_q != 2'd0);
  assign almost_empty_o = almost_empty_q;
  assign data_count_o   = data_count_q;
  assign ram_wr_en_o    = push_acc_s;
  assign ram_wr_addr_o  = wr_ptr_q;
  assign ram_wr_data_o  = wr_data_i;
  assign ram_rd_addr_o  = rd_ptr_q;

endmodule
